// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions: datapath widths, decrypt-controller state type,
// and FIPS-197 reference vectors for benches.
package aes_128_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } dec_ctrl_state_t;

    // FIPS-197 Appendix B example (ciphertext, key, plaintext).
    localparam logic [AES_BLOCK_W-1:0] FIPS197_B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [AES_KEY_W-1:0]   FIPS197_B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [AES_BLOCK_W-1:0] FIPS197_B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    // FIPS-197 Appendix C.1 example (ciphertext, key, plaintext).
    localparam logic [AES_BLOCK_W-1:0] FIPS197_C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [AES_KEY_W-1:0]   FIPS197_C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BLOCK_W-1:0] FIPS197_C_PT  = 128'h00112233445566778899aabbccddeeff;

endpackage

// File: rtl/aes_128_dec_ctrl.sv
// Handshake sequencer around the combinational AES-128 decryptor.
// Latches block/key into the datapath, waits SETTLE_CYCLES clocks for the
// multicycle path, then captures and holds the plaintext until retired.
module aes_128_dec_ctrl
    import aes_128_pkg::*;
#(
    parameter  int SETTLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic [AES_KEY_W-1:0]   in_key,
    output logic [AES_BLOCK_W-1:0] dp_in,
    output logic [AES_KEY_W-1:0]   dp_key,
    input  logic [AES_BLOCK_W-1:0] dp_cipher,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy,
    output logic [15:0]            blk_count
);

    if (SETTLE_CYCLES < 1) begin : g_bad_param
        $error("aes_128_dec_ctrl: SETTLE_CYCLES must be >= 1");
    end

    dec_ctrl_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] dp_in_q, dp_in_d;
    logic [AES_KEY_W-1:0]   dp_key_q, dp_key_d;
    logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [15:0]            blk_q, blk_d;
    logic                   accept;

    // Next-state: settle countdown, capture, retire, then a new accept
    // (which may coincide with a retire) overrides state and counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dp_in_d     = dp_in_q;
        dp_key_d    = dp_key_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        blk_d       = blk_q;
        // Combinational through out_ready so a retiring block frees the slot
        // on the same edge.
        in_ready    = (state_q == IDLE) || ((state_q == OUT) && out_ready);
        accept      = in_valid && in_ready;

        unique case (state_q)
            IDLE: ;
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_data_d  = dp_cipher;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    blk_d       = blk_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Datapath inputs move only here, keeping the multicycle path stable.
        if (accept) begin
            dp_in_d  = in_data;
            dp_key_d = in_key;
            cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
        end
    end

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dp_in_q     <= '0;
            dp_key_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dp_in_q     <= dp_in_d;
            dp_key_q    <= dp_key_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            blk_q       <= blk_d;
        end
    end

    assign dp_in     = dp_in_q;
    assign dp_key    = dp_key_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign blk_count = blk_q;

endmodule

// File: doc/aes_128_dec_ctrl.md
Name: aes_128_dec_ctrl

Overview:
Sequencer that wraps the combinational AES-128 decryptor (`AES_128_Decryptor`) with valid/ready handshakes.
- Registers block and key into the datapath inputs, then waits a fixed number of clocks for the deep combinational path to settle.
- Captures the plaintext and presents it downstream, holding it under backpressure.
- Sits between the bus-side block source and the decryptor. The decryptor is instantiated outside and connected through the dp_* ports.

Parameters:
- SETTLE_CYCLES, 4: clocks allowed for the decryptor to settle, i.e. the multicycle-path budget. Must be >= 1; a value < 1 is an elaboration error.
- CNT_W, $clog2(SETTLE_CYCLES+1): settle counter width. Derived; never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  source presents a block.
- in_ready  out  1  controller accepts a block this cycle.
- in_data  in  128  ciphertext block.
- in_key  in  128  cipher key for this block.
- dp_in  out  128  registered ciphertext to the decryptor `in` port.
- dp_key  out  128  registered key to the decryptor `key` port.
- dp_cipher  in  128  decryptor result (its `cipher` output, i.e. the plaintext).
- out_valid  out  1  plaintext available.
- out_ready  in  1  sink accepts the plaintext.
- out_data  out  128  captured plaintext.
- busy  out  1  high whenever state != IDLE.
- blk_count  out  16  number of blocks retired (out_valid && out_ready); wraps 0xFFFF -> 0x0000.

Behaviour:
- States: IDLE, SETTLE, OUT.
- Reset (rst_n low at a rising edge): state = IDLE, counter = 0, blk_count = 0, out_valid = 0. dp_in, dp_key and out_data are all zero.
  - Any in-flight block is discarded and no out_valid is produced for it.
  - Reset takes priority over every other event.
- in_ready = (state == IDLE) || (state == OUT && out_ready). This is combinational from out_ready and intentional.
- Accept = in_valid && in_ready. On the accept edge:
  - dp_in <= in_data, dp_key <= in_key.
  - counter <= SETTLE_CYCLES-1.
  - state <= SETTLE.
- SETTLE:
  - in_ready = 0, and in_valid/in_data/in_key are ignored.
  - dp_in/dp_key are held stable.
  - While counter != 0, counter decrements by 1 each clock.
  - At the edge where counter == 0: out_data <= dp_cipher, out_valid <= 1, state <= OUT.
- Latency: capture occurs at accept edge + SETTLE_CYCLES clocks, and out_valid is high from that edge onward.
- OUT:
  - out_data and out_valid are held stable while out_ready = 0.
  - out_ready = 1 with no accept: out_valid <= 0, state <= IDLE, blk_count increments.
  - out_ready = 1 with accept on the same edge: the retire and the new accept both take effect. blk_count increments, a new SETTLE starts, and out_valid <= 0.
- dp_in/dp_key change only on accept edges. They are never modified in SETTLE or OUT, which keeps the multicycle path valid.
- Throughput: one block per SETTLE_CYCLES+1 clocks with out_ready held high. There is no overlap of settling blocks.
- blk_count wraps silently with no flag.
- out_data keeps its last value after retire; consumers must qualify it with out_valid.
- X on in_data while in_valid = 0 must not propagate to dp_in.

Decomposition:
- Shared package aes_128_pkg holds:
  - AES_BLOCK_W = 128 and AES_KEY_W = 128.
  - typedef dec_ctrl_state_t {IDLE, SETTLE, OUT}, 2-bit encoding.
  - The NIST FIPS-197 test vectors as localparams, for benches.
- No sub-module: the single FSM, counter and registers stay in one file.
- The decryptor is instantiated by the integrating top, and the multicycle constraint (SETTLE_CYCLES) on dp_* -> out_data is declared there.

Test Plan:
1. SETTLE_CYCLES=4, out_ready=1. Accept in_data=3925841d02dc09fbdc118597196a0b32, in_key=2b7e151628aed2a6abf7158809cf4f3c at edge 0 -> out_valid high after edge 4, out_data=3243f6a8885a308d313198a2e0370734, blk_count=1, busy low after edge 5.
2. Back-to-back, out_ready=1. Second block 69c4e0d86a7b0430d8cdb78070b4c55a with key 000102030405060708090a0b0c0d0e0f held valid -> accepted on the same edge the first retires; out_data=00112233445566778899aabbccddeeff 4 clocks later; blk_count=2.
3. Backpressure: out_ready=0 for 10 clocks in OUT while in_valid toggles with new data -> in_ready=0, out_data and dp_in unchanged, blk_count unchanged; retire on the first out_ready=1.
4. Reset mid-SETTLE: rst_n=0 at edge 2 after accept -> state IDLE, out_valid never asserts, dp_in=dp_key=out_data=0, blk_count=0, in_ready=1 next clock.
5. SETTLE_CYCLES=1 instance: accept at edge 0 -> out_valid after edge 1 with correct NIST plaintext. In SETTLE, verify that dp_in holds when in_data changes.
6. Identity stub datapath, 65537 blocks retired -> blk_count wraps to 0x0001, and every out_data equals its in_data.
